// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, operands and
// result exchanged over valid/ready handshakes. Divide-by-zero returns Q=all-ones, R=A.
module seq_restoring_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             DZ
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    // Partial remainder is always < divisor, so its WIDTH low bits hold it exactly;
    // the extra bit of the WIDTH+1-bit trial subtract only serves as the borrow.
    logic [WIDTH-1:0] p, s, b;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] p_nxt, s_nxt;
    logic             last;

    assign t    = {p, s[WIDTH-1]} - {1'b0, b};
    assign last = (cnt == CW'(WIDTH - 1));

    always_comb begin
        if (!t[WIDTH]) begin
            p_nxt = t[WIDTH-1:0];
            s_nxt = {s[WIDTH-2:0], 1'b1};
        end else begin
            p_nxt = {p[WIDTH-2:0], s[WIDTH-1]};
            s_nxt = {s[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = (B == '0) ? DONE : RUN;
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p   <= '0;
            s   <= '0;
            b   <= '0;
            cnt <= '0;
            Q   <= '0;
            R   <= '0;
            DZ  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        b   <= B;
                        p   <= '0;
                        s   <= A;
                        cnt <= '0;
                        if (B == '0) begin
                            Q  <= '1;
                            R  <= A;
                            DZ <= 1'b1;
                        end else begin
                            DZ <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    p   <= p_nxt;
                    s   <= s_nxt;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        Q <= s_nxt;
                        R <= p_nxt;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
